// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared state type and default geometry for the FFT frame sequencer.
package fft_seq_pkg;
  localparam int BW_DEF = 16;
  localparam int N_DEF = 512;
  localparam int RD_LAT_DEF = 1;
  localparam int HALF_BINS = N_DEF / 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_START,
    S_WAIT,
    S_SCAN,
    S_REPORT
  } state_t;
endpackage

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: |re|+|im| of one complex bin and a registered running maximum with its bin index.
module fft_peak_tracker
  import fft_seq_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int BINW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BINW-1:0]   i_bin,
  input  logic [2*BW-1:0]   i_data,
  output logic [BINW-1:0]   o_bin,
  output logic [BW:0]       o_mag
);
  logic signed [BW:0] w_re;
  logic signed [BW:0] w_im;
  logic [BW:0] w_mag;
  // One guard bit keeps |-2^(BW-1)| exact; the sum of two such values still fits BW+1 bits.
  assign w_re = {i_data[BW-1], i_data[BW-1:0]};
  assign w_im = {i_data[2*BW-1], i_data[2*BW-1:BW]};
  assign w_mag = (w_re[BW] ? -w_re : w_re) + (w_im[BW] ? -w_im : w_im);
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      o_bin <= '0;
      o_mag <= '0;
    end else if (i_en && w_mag > o_mag) begin
      o_bin <= i_bin;
      o_mag <= w_mag;
    end
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads N samples into the FFT core, starts it, scans the half spectrum and reports the peak bin.
// Optional FFT_SEQ_MAG_THRESH_EN: weak peaks (below MAG_THRESH) pulse no_signal instead of result_valid.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int N = N_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
`ifdef FFT_SEQ_MAG_THRESH_EN
  parameter int MAG_THRESH = 64,
`endif
  parameter int M = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            s_valid,
  input  logic [BW-1:0]   s_data,
  output logic            s_ready,
  output logic            fft_reset,
  output logic            fft_load,
  output logic            fft_start,
  output logic [M-1:0]    fft_rd_adr,
  output logic [2*BW-1:0] fft_wd,
  input  logic            fft_done,
  input  logic [2*BW-1:0] fft_rdata,
  output logic [M-2:0]    peak_bin,
  output logic [BW:0]     peak_mag,
  output logic            result_valid,
`ifdef FFT_SEQ_MAG_THRESH_EN
  output logic            no_signal,
`endif
  output logic            busy
);
  localparam int HALF = N / 2;
  localparam int SW = $clog2(HALF + RD_LAT + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(HALF + RD_LAT - 1);
  localparam logic [SW-1:0] FIRST_BIN = SW'(RD_LAT + 1);
  state_t r_state;
  state_t w_next;
  logic [M-1:0] r_cnt;
  logic [SW-1:0] r_scan;
  logic [M-2:0] r_peak_bin;
  logic [BW:0] r_peak_mag;
  logic [M-2:0] w_trk_bin;
  logic [BW:0] w_trk_mag;
  logic [M-2:0] w_bin;
  logic w_hs;
  logic w_last;
  logic w_scan_end;
  logic w_clr;
  logic w_en;
`ifdef FFT_SEQ_MAG_THRESH_EN
  logic w_strong;
  assign w_strong = w_trk_mag >= (BW+1)'(MAG_THRESH);
`endif
  assign w_hs = (r_state == S_LOAD) && s_valid;
  assign w_last = w_hs && (r_cnt == M'(N - 1));
  assign w_scan_end = (r_state == S_SCAN) && (r_scan == SCAN_LAST);
  assign w_clr = (r_state == S_WAIT) && fft_done;
  // DC (bin 0) is skipped, so evaluation starts one cycle after the read latency.
  assign w_en = (r_state == S_SCAN) && (r_scan >= FIRST_BIN);
  assign w_bin = (M-1)'(r_scan - SW'(RD_LAT));
  assign fft_rd_adr = r_cnt;
  assign fft_wd = {{BW{1'b0}}, s_data};
  assign busy = r_state != S_IDLE;
  assign peak_bin = (r_state == S_REPORT) ? w_trk_bin : r_peak_bin;
  assign peak_mag = (r_state == S_REPORT) ? w_trk_mag : r_peak_mag;
  always_comb begin
    w_next = r_state;
    s_ready = 1'b0;
    fft_load = 1'b0;
    fft_start = 1'b0;
    fft_reset = ~reset;
    result_valid = 1'b0;
`ifdef FFT_SEQ_MAG_THRESH_EN
    no_signal = 1'b0;
`endif
    case (r_state)
      S_IDLE: w_next = run ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        fft_reset = 1'b1;
        w_next = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        fft_load = s_valid;
        w_next = w_last ? S_START : S_LOAD;
      end
      S_START: begin
        fft_start = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: w_next = fft_done ? S_SCAN : S_WAIT;
      S_SCAN: w_next = w_scan_end ? S_REPORT : S_SCAN;
      S_REPORT: begin
`ifdef FFT_SEQ_MAG_THRESH_EN
        result_valid = w_strong;
        no_signal = ~w_strong;
`else
        result_valid = 1'b1;
`endif
        w_next = run ? S_CLEAR : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_scan <= '0;
      r_peak_bin <= '0;
      r_peak_mag <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == S_CLEAR) ? '0 : r_cnt + M'(w_hs);
      r_scan <= (r_state == S_SCAN) ? r_scan + SW'(1) : '0;
      if (r_state == S_REPORT) begin
        r_peak_bin <= w_trk_bin;
        r_peak_mag <= w_trk_mag;
      end
    end
  end
  fft_peak_tracker #(
    .BW(BW),
    .BINW(M - 1)
  ) u_trk (
    .clk(clk),
    .reset(reset),
    .i_clr(w_clr),
    .i_en(w_en),
    .i_bin(w_bin),
    .i_data(fft_rdata),
    .o_bin(w_trk_bin),
    .o_mag(w_trk_mag)
  );
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: random frames through a simple FFT core model, checked against a spectrum-level peak model.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
  import fft_seq_pkg::*;
  localparam int BW = 16;
  localparam int N = 512;
  localparam int M = 9;
  localparam int HALF = HALF_BINS;
  localparam int RD_LAT = 1;
  localparam int THRESH = 64;
`ifdef FFT_SEQ_MAG_THRESH_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic s_valid = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic s_ready, fft_reset, fft_load, fft_start, result_valid, busy, no_sig;
  logic fft_done = 1'b0;
  logic [M-1:0] fft_rd_adr;
  logic [2*BW-1:0] fft_wd;
  logic [2*BW-1:0] fft_rdata = '0;
  logic [M-2:0] peak_bin;
  logic [BW:0] peak_mag;
  fft_frame_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fft_reset(fft_reset), .fft_load(fft_load), .fft_start(fft_start), .fft_rd_adr(fft_rd_adr),
    .fft_wd(fft_wd), .fft_done(fft_done), .fft_rdata(fft_rdata), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .result_valid(result_valid),
`ifdef FFT_SEQ_MAG_THRESH_EN
    .no_signal(no_sig),
`endif
    .busy(busy)
  );
`ifndef FFT_SEQ_MAG_THRESH_EN
  assign no_sig = 1'b0;
`endif
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Spectrum the core hands back: first half only, {im, re} per bin.
  logic signed [BW-1:0] bre [HALF];
  logic signed [BW-1:0] bim [HALF];
  function automatic int absv(input int x);
    return x < 0 ? -x : x;
  endfunction
  function automatic void best(output int b, output int m);
    b = 0;
    m = 0;
    for (int k = 1; k < HALF; k++) begin
      int a;
      a = absv(int'(bre[k])) + absv(int'(bim[k]));
      if (a > m) begin
        m = a;
        b = k;
      end
    end
  endfunction
  task automatic set_bins(input int mode);
    for (int k = 0; k < HALF; k++) begin
      bre[k] = mode == 0 ? 16'sd0 : mode == 1 ? BW'($urandom) : BW'($signed($urandom_range(0, 1998)) - 999);
      bim[k] = mode == 0 ? 16'sd0 : mode == 1 ? BW'($urandom) : BW'($signed($urandom_range(0, 1998)) - 999);
    end
  endtask
  // Core model and sample source, both updated just after each rising edge.
  int dly = 20;
  int vmode = 2;
  initial begin
    logic c_start, c_reset, c_hs, armed;
    int tmr, dcnt;
    armed = 1'b0;
    tmr = 0;
    dcnt = 0;
    forever begin
      @(negedge clk);
      c_start = fft_start;
      c_reset = fft_reset;
      c_hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (c_reset) begin
        armed = 1'b0;
        tmr = 0;
        dcnt = 0;
        fft_done = 1'b0;
      end else begin
        if (fft_done) dcnt++;
        if (c_start) begin
          armed = 1'b1;
          tmr = 1;
        end else if (armed) tmr++;
        fft_done = armed && tmr >= dly;
      end
      fft_rdata = (dcnt >= 2 && dcnt - 2 < HALF) ? {bim[dcnt-2], bre[dcnt-2]} : $urandom;
      if (!s_valid || c_hs) begin
        s_valid = vmode == 0 ? !s_valid : vmode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data = BW'($urandom);
      end
    end
  end
  // Frame-level expectations: -1 marks "no event scheduled".
  bit chk_on = 0;
  int cyc = 0;
  bit m_idle = 1, m_loading = 0, m_wait = 0;
  int m_hs = 0, m_clr_cyc = -1, m_start_cyc = -1, m_rv_cyc = -1;
  int m_ebin = 0, m_emag = 0, m_pbin = 0, m_pmag = 0;
  int n_start = 0, n_rv = 0, n_ns = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on) begin
        if (cyc == m_rv_cyc) begin
          m_pbin = m_ebin;
          m_pmag = m_emag;
        end
        chk("s_ready", s_ready, m_loading);
        chk("fft_load", fft_load, m_loading && s_valid);
        chk("busy", busy, !m_idle);
        chk("fft_reset", fft_reset, !reset || cyc == m_clr_cyc);
        chk("fft_start", fft_start, cyc == m_start_cyc);
        chk("result_valid", result_valid, cyc == m_rv_cyc && (THR == 0 || m_emag >= THRESH));
`ifdef FFT_SEQ_MAG_THRESH_EN
        chk("no_signal", no_sig, cyc == m_rv_cyc && m_emag < THRESH);
`endif
        chk("peak_bin", peak_bin, m_pbin);
        chk("peak_mag", peak_mag, m_pmag);
        if (m_loading && s_valid) begin
          chk("fft_rd_adr", fft_rd_adr, m_hs);
          chk("fft_wd", fft_wd, {16'h0, s_data});
        end
      end
      n_start += int'(fft_start);
      n_rv += int'(result_valid);
      n_ns += int'(no_sig);
      if (!reset) begin
        m_idle = 1;
        m_loading = 0;
        m_wait = 0;
        m_hs = 0;
        m_clr_cyc = -1;
        m_start_cyc = -1;
        m_rv_cyc = -1;
        m_pbin = 0;
        m_pmag = 0;
      end else begin
        if (m_loading && s_valid) begin
          m_hs++;
          if (m_hs == N) begin
            m_loading = 0;
            m_start_cyc = cyc + 1;
          end
        end
        if (cyc == m_clr_cyc) begin
          m_loading = 1;
          m_hs = 0;
        end
        if (cyc == m_start_cyc) m_wait = 1;
        else if (m_wait && fft_done) begin
          m_wait = 0;
          m_rv_cyc = cyc + HALF + RD_LAT + 1;
          best(m_ebin, m_emag);
        end
        if (m_idle && run) begin
          m_idle = 0;
          m_clr_cyc = cyc + 1;
        end else if (cyc == m_rv_cyc) begin
          if (run) m_clr_cyc = cyc + 1;
          else m_idle = 1;
        end
      end
    end
  end
  task automatic wait_result(input int target);
    int t;
    t = 0;
    while (n_rv + n_ns < target && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk("result_timeout", t < 6000, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    set_bins(0);
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    @(negedge clk);
    chk("rst_fft_reset", fft_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_peak_mag", peak_mag, 0);
    @(posedge clk);
    #1;
    reset = 1;
    run = 1;
    vmode = 2;
    t = 0;
    while (m_hs < 100 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("load_100_timeout", t < 2000, 1);
    reset = 0;
    @(negedge clk);
    chk("midrst_fft_reset", fft_reset, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_no_start", n_start, 0);
    bre[37] = 16'sd400;
    bim[37] = -16'sd300;
    vmode = 0;
    @(posedge clk);
    #1;
    reset = 1;
    wait_result(1);
    chk("A_peak_bin", peak_bin, 37);
    chk("A_peak_mag", peak_mag, 700);
    chk("A_one_start", n_start, 1);
    set_bins(0);
    bre[0] = 16'sd9000;
    bre[10] = 16'sd250;
    bim[10] = -16'sd250;
    bre[20] = -16'sd500;
    vmode = 1;
    dly = 1;
    wait_result(2);
    chk("B_peak_bin", peak_bin, 10);
    chk("B_peak_mag", peak_mag, 500);
    set_bins(2);
    bre[5] = 16'sh8000;
    bim[5] = 16'sh8000;
    dly = 7;
    wait_result(3);
    chk("C_peak_bin", peak_bin, 5);
    chk("C_peak_mag", peak_mag, 65536);
    for (int f = 0; f < 2; f++) begin
      set_bins(1);
      dly = $urandom_range(1, 40);
      wait_result(4 + f);
    end
    set_bins(0);
    bre[3] = 16'sd30;
    bim[3] = -16'sd20;
    dly = 30;
    t = 0;
    while (n_start < 6 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("E_start_timeout", t < 3000, 1);
    run = 0;
    wait_result(6);
    repeat (5) @(negedge clk);
    chk("E_peak_bin", peak_bin, 3);
    chk("E_peak_mag", peak_mag, 50);
    chk("E_busy", busy, 0);
    chk("rv_count", n_rv, 6 - THR);
    chk("no_signal_count", n_ns, THR);
    chk("start_count", n_start, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Frame-level scheduler wrapped around the FFT core (control unit + RAMs + BFU).
- Sequence per frame: accept N real audio samples on a valid/ready stream and write them through the core's load path; pulse start; wait for done; scan the first-half output bins.
- Reports the peak-magnitude bin to the tuner back end once per frame.
- Re-arms the core between frames. The core's done output is sticky until its reset.

Parameters:
- BW, 16, sample and FFT data width (per real/imag component).
- N, 512, FFT length (power of 2).
- M, $clog2(N), address width.
- RD_LAT, 1, cycles from the core's done-state output index to valid fft_rdata.
- MAG_THRESH, 64, minimum peak magnitude; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- run  in  1  level; 1 = process frames continuously.
- s_valid  in  1  sample valid.
- s_data  in  BW  signed sample.
- s_ready  out  1  sequencer accepts a sample this cycle.
- fft_reset  out  1  active-high reset to the FFT core.
- fft_load  out  1  load strobe to the core.
- fft_start  out  1  one-cycle start pulse to the core.
- fft_rd_adr  out  M  natural-order sample index during load (the core bit-reverses it).
- fft_wd  out  2*BW  {imag=0, real=s_data}.
- fft_done  in  1  core finished; held until fft_reset.
- fft_rdata  in  2*BW  {imag, real} signed output bin.
- peak_bin  out  M-1  bin index of the maximum.
- peak_mag  out  BW+1  |re|+|im| of the maximum, unsigned.
- result_valid  out  1  one-cycle pulse; peak_* valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at clk edge), from any state including mid-frame:
  - State goes to IDLE.
  - All counters are 0.
  - peak_bin=0, peak_mag=0, result_valid=0, s_ready=0, fft_load=0, fft_start=0.
  - fft_reset=1 while reset is asserted.
- FSM states: IDLE, CLEAR, LOAD, START, WAIT, SCAN, REPORT.
- IDLE:
  - Outputs idle.
  - run=1 → CLEAR.
- CLEAR:
  - fft_reset=1 for exactly 1 cycle; sample counter cleared.
  - Next state is LOAD.
- LOAD:
  - s_ready=1.
  - fft_load = s_valid & s_ready.
  - fft_rd_adr = sample counter; fft_wd = {BW'0, s_data}.
  - Counter increments on each handshake.
  - The handshake with counter==N-1 → START. No s_ready in the following cycle.
  - Stalls (s_valid=0) are unlimited. Samples are never dropped inside the sequencer; upstream holds them.
- START:
  - fft_start=1 for 1 cycle.
  - Next state is WAIT.
- WAIT:
  - Stay until fft_done=1, then → SCAN with the scan counter = 0.
- SCAN:
  - Runs N/2 + RD_LAT cycles.
  - The sample on scan cycle c (c ≥ RD_LAT) is bin k = c − RD_LAT.
  - Only bins 1..N/2−1 are evaluated; DC bin 0 is always skipped.
  - mag = |re| + |im|, computed in BW+1 bits. Abs of −2^(BW−1) is 2^(BW−1), no saturation needed.
  - Running max updates on strict > only, so ties keep the lowest bin.
  - The running max is cleared on entry to SCAN.
- REPORT:
  - Latch the running max to peak_bin/peak_mag; result_valid=1 for 1 cycle.
  - run=1 → CLEAR; run=0 → IDLE.
  - peak_* hold their value until the next REPORT.
- run deasserted mid-frame: the current frame completes through REPORT, then IDLE.
- fft_done is ignored outside WAIT.
- fft_start is never asserted outside START, and fft_load never outside LOAD.
- Frame latency, from the last sample handshake to result_valid: 1 (START) + core compute time (WAIT) + N/2 + RD_LAT (SCAN) + 1 (REPORT).

Optional Feature:
- Macro: FFT_SEQ_MAG_THRESH_EN.
- When defined:
  - At REPORT, if peak_mag < MAG_THRESH, result_valid stays 0.
  - An extra output `no_signal` (1 bit) pulses instead.
  - peak_* still update.
- When undefined:
  - result_valid pulses every frame.
  - The no_signal port does not exist.

Decomposition:
- Package fft_seq_pkg holds:
  - the state enum type;
  - defaults for BW, N and RD_LAT;
  - a localparam for half-spectrum bins (N/2).
- One sub-module, fft_peak_tracker:
  - combinational |re|+|im|;
  - registered running max/bin with clear and enable inputs.
- The FSM and counters stay in fft_frame_sequencer.

Test Plan:
- Reset mid-LOAD (after 100 samples) → state IDLE, s_ready=0, fft_reset=1 during reset, no fft_start ever issued.
- run=1, 512 samples with s_valid toggling every other cycle → fft_rd_adr steps 0..511 once each, exactly one fft_start pulse after the 512th handshake, s_ready=0 afterwards.
- Core model asserts fft_done 20 cycles after start, returns bin 37 = {im=−300, re=400}, all other bins 0 → after RD_LAT+256 scan cycles, result_valid=1 with peak_bin=37, peak_mag=700.
- Bins 10 and 20 both give mag 500, bin 0 gives mag 9000 → peak_bin=10, peak_mag=500 (DC skipped, tie goes to the lower bin).
- Bin re = −32768, im = −32768 → peak_mag=65536, no overflow.
- run dropped during WAIT → frame completes, one result_valid, then busy=0 with no CLEAR. With FFT_SEQ_MAG_THRESH_EN and a max mag of 50 → no_signal pulses, result_valid stays 0.
